axi2ahb_burst_ctrl: RTL

AXI2AHB_BURST_CTRL -- requirements
Module: axi2ahb_burst_ctrl

---
 rtl/axi2ahb_burst_ctrl_if.sv | 44 ++++
 rtl/axi2ahb_burst_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi2ahb_burst_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : axi2ahb_burst_ctrl_if
// Brief    : Command, data-flow and AHB master signals of the burst controller.
// Revision : 1.0
// ============================================================================
interface axi2ahb_burst_ctrl_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 8
);
  logic                  cmd_valid_i;
  logic                  cmd_ready_o;
  logic                  cmd_write_i;
  logic [ADDR_WIDTH-1:0] cmd_addr_i;
  logic [LEN_WIDTH-1:0]  cmd_len_i;
  logic [1:0]            cmd_burst_i;
  logic                  data_ready_i;
  logic [ADDR_WIDTH-1:0] HADDR;
  logic [2:0]            HBURST;
  logic [2:0]            HSIZE;
  logic [1:0]            HTRANS;
  logic                  HWRITE;
  logic                  HREADY;
  logic                  HRESP;
  logic                  dphase_valid_o;
  logic                  dphase_last_o;
  logic                  err_o;

  // master is the controller itself (it masters the AHB bus); slave is its environment
  modport master (
    input  cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_len_i, cmd_burst_i, data_ready_i,
    input  HREADY, HRESP,
    output cmd_ready_o, HADDR, HBURST, HSIZE, HTRANS, HWRITE,
    output dphase_valid_o, dphase_last_o, err_o
  );

  modport slave (
    output cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_len_i, cmd_burst_i, data_ready_i,
    output HREADY, HRESP,
    input  cmd_ready_o, HADDR, HBURST, HSIZE, HTRANS, HWRITE,
    input  dphase_valid_o, dphase_last_o, err_o
  );
endinterface
`default_nettype wire

// File: rtl/axi2ahb_burst_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : axi2ahb_burst_ctrl
// Brief    : Turns FIXED/INCR/WRAP burst commands into AHB address/data phases.
// Revision : 1.0
// ============================================================================
module axi2ahb_burst_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                 ACLK,
  input  logic                 ARESETN,
  axi2ahb_burst_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_DRAIN  = 2'd2,
    S_ERR    = 2'd3
  } state_t;

  localparam logic [1:0] c_HT_IDLE   = 2'b00;
  localparam logic [1:0] c_HT_BUSY   = 2'b01;
  localparam logic [1:0] c_HT_NONSEQ = 2'b10;
  localparam logic [1:0] c_HT_SEQ    = 2'b11;

  localparam logic [2:0] c_HB_SINGLE = 3'd0;
  localparam logic [2:0] c_HB_INCR   = 3'd1;
  localparam logic [2:0] c_HB_WRAP4  = 3'd2;
  localparam logic [2:0] c_HB_INCR4  = 3'd3;
  localparam logic [2:0] c_HB_WRAP8  = 3'd4;
  localparam logic [2:0] c_HB_INCR8  = 3'd5;
  localparam logic [2:0] c_HB_WRAP16 = 3'd6;
  localparam logic [2:0] c_HB_INCR16 = 3'd7;

  localparam logic [1:0] c_BURST_FIXED = 2'd0;
  localparam logic [1:0] c_BURST_WRAP  = 2'd2;

  localparam int                    c_SZ_LOG2  = (DATA_WIDTH == 64) ? 3 : 2;
  localparam logic [2:0]            c_HSIZE    = (DATA_WIDTH == 64) ? 3'b011 : 3'b010;
  localparam logic [ADDR_WIDTH-1:0] c_STEP     = ADDR_WIDTH'(DATA_WIDTH / 8);
  localparam logic [ADDR_WIDTH-1:0] c_ONE_ADDR = ADDR_WIDTH'(1);
  localparam logic [LEN_WIDTH:0]    c_ONE_CNT  = (LEN_WIDTH+1)'(1);

  state_t                r_state, w_state;
  logic                  r_write, w_write;
  logic [LEN_WIDTH-1:0]  r_len, w_len;
  logic [1:0]            r_burst, w_burst;
  logic [2:0]            r_hb_code, w_hb_code;
  logic                  r_single, w_single;
  logic [LEN_WIDTH:0]    r_cnt, w_cnt;
  logic [ADDR_WIDTH-1:0] r_next_addr, w_next_addr;
  logic [ADDR_WIDTH-1:0] r_haddr, w_haddr;
  logic [1:0]            r_htrans, w_htrans;
  logic [2:0]            r_hburst, w_hburst;
  logic                  r_hwrite, w_hwrite;
  logic                  r_dp_pending, w_dp_pending;
  logic                  r_dp_last, w_dp_last;
  logic                  r_err, w_err;

  logic [LEN_WIDTH:0]    w_total;
  logic                  w_all_issued;
  logic                  w_beat_on_bus;
  logic                  w_abort;
  logic                  w_is_incr;
  logic [ADDR_WIDTH-1:0] w_incr_addr;
  logic [ADDR_WIDTH-1:0] w_wrap_mask;
  logic [ADDR_WIDTH-1:0] w_step_addr;
  logic [1:0]            w_beat_trans;
  logic [ADDR_WIDTH-1:0] w_cmd_end;
  logic                  w_cmd_cross;
  logic                  w_cmd_pow2;
  logic [2:0]            w_cmd_hb;
  logic                  w_cmd_single;

  assign w_total       = {1'b0, r_len} + c_ONE_CNT;
  assign w_all_issued  = (r_cnt == w_total);
  assign w_beat_on_bus = r_htrans[1];
  assign w_abort       = bus.HRESP && !bus.HREADY;
  assign w_is_incr     = (r_burst != c_BURST_FIXED) && (r_burst != c_BURST_WRAP);

  // Wrap window is the whole burst size, aligned to itself
  assign w_incr_addr = r_next_addr + c_STEP;
  assign w_wrap_mask = (ADDR_WIDTH'(w_total) << c_SZ_LOG2) - c_ONE_ADDR;

  always_comb begin
    w_step_addr = w_incr_addr;
    if (r_burst == c_BURST_FIXED) begin
      w_step_addr = r_next_addr;
    end else if (r_burst == c_BURST_WRAP) begin
      w_step_addr = (r_next_addr & ~w_wrap_mask) | (w_incr_addr & w_wrap_mask);
    end
  end

  // A beat restarts as NONSEQ when it opens the burst, is a standalone single, or sits on a 1KB line
  assign w_beat_trans = ((r_cnt == '0) || r_single || (w_is_incr && (r_next_addr[9:0] == 10'd0)))
                        ? c_HT_NONSEQ : c_HT_SEQ;

  assign w_cmd_end   = bus.cmd_addr_i + (ADDR_WIDTH'(bus.cmd_len_i) << c_SZ_LOG2);
  assign w_cmd_cross = (bus.cmd_addr_i[ADDR_WIDTH-1:10] != w_cmd_end[ADDR_WIDTH-1:10]);
  assign w_cmd_pow2  = (bus.cmd_len_i == LEN_WIDTH'(3)) || (bus.cmd_len_i == LEN_WIDTH'(7)) ||
                       (bus.cmd_len_i == LEN_WIDTH'(15));

  always_comb begin
    w_cmd_hb     = c_HB_INCR;
    w_cmd_single = 1'b0;
    if (bus.cmd_burst_i == c_BURST_FIXED) begin
      w_cmd_hb     = c_HB_SINGLE;
      w_cmd_single = 1'b1;
    end else if (bus.cmd_burst_i == c_BURST_WRAP) begin
      if (bus.cmd_len_i == LEN_WIDTH'(3)) begin
        w_cmd_hb = c_HB_WRAP4;
      end else if (bus.cmd_len_i == LEN_WIDTH'(7)) begin
        w_cmd_hb = c_HB_WRAP8;
      end else if (bus.cmd_len_i == LEN_WIDTH'(15)) begin
        w_cmd_hb = c_HB_WRAP16;
      end else begin
        w_cmd_hb     = c_HB_SINGLE;
        w_cmd_single = 1'b1;
      end
    end else if (!w_cmd_cross && w_cmd_pow2) begin
      if (bus.cmd_len_i == LEN_WIDTH'(3)) begin
        w_cmd_hb = c_HB_INCR4;
      end else if (bus.cmd_len_i == LEN_WIDTH'(7)) begin
        w_cmd_hb = c_HB_INCR8;
      end else begin
        w_cmd_hb = c_HB_INCR16;
      end
    end
  end

  always_comb begin
    w_state      = r_state;
    w_write      = r_write;
    w_len        = r_len;
    w_burst      = r_burst;
    w_hb_code    = r_hb_code;
    w_single     = r_single;
    w_cnt        = r_cnt;
    w_next_addr  = r_next_addr;
    w_haddr      = r_haddr;
    w_htrans     = r_htrans;
    w_hburst     = r_hburst;
    w_hwrite     = r_hwrite;
    w_dp_pending = r_dp_pending;
    w_dp_last    = r_dp_last;
    w_err        = 1'b0;

    if (bus.HREADY) begin
      w_dp_pending = w_beat_on_bus;
      w_dp_last    = w_beat_on_bus && w_all_issued;
    end

    case (r_state)
      S_IDLE: begin
        if (bus.cmd_valid_i) begin
          w_write     = bus.cmd_write_i;
          w_len       = bus.cmd_len_i;
          w_burst     = bus.cmd_burst_i;
          w_hb_code   = w_cmd_hb;
          w_single    = w_cmd_single;
          w_next_addr = bus.cmd_addr_i;
          w_cnt       = '0;
          w_state     = S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        if (w_abort) begin
          w_htrans     = c_HT_IDLE;
          w_hburst     = c_HB_SINGLE;
          w_hwrite     = 1'b0;
          w_dp_pending = 1'b0;
          w_dp_last    = 1'b0;
          w_state      = S_ERR;
        end else if (bus.HREADY) begin
          if (w_all_issued) begin
            w_htrans = c_HT_IDLE;
            w_hburst = c_HB_SINGLE;
            w_hwrite = 1'b0;
            w_state  = S_DRAIN;
          end else if (bus.data_ready_i) begin
            w_haddr     = r_next_addr;
            w_htrans    = w_beat_trans;
            w_hburst    = r_hb_code;
            w_hwrite    = r_write;
            w_cnt       = r_cnt + c_ONE_CNT;
            w_next_addr = w_step_addr;
          end else if (r_cnt == '0) begin
            w_htrans = c_HT_IDLE;
            w_hwrite = 1'b0;
          end else begin
            w_haddr  = r_next_addr;
            w_htrans = c_HT_BUSY;
            w_hburst = r_hb_code;
            w_hwrite = r_write;
          end
        end
      end
      S_DRAIN: begin
        if (w_abort) begin
          w_dp_pending = 1'b0;
          w_dp_last    = 1'b0;
          w_state      = S_ERR;
        end else if (bus.HREADY) begin
          w_state = S_IDLE;
        end
      end
      S_ERR: begin
        if (bus.HREADY) begin
          w_err   = 1'b1;
          w_state = S_IDLE;
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      r_state      <= S_IDLE;
      r_write      <= 1'b0;
      r_len        <= '0;
      r_burst      <= '0;
      r_hb_code    <= c_HB_SINGLE;
      r_single     <= 1'b0;
      r_cnt        <= '0;
      r_next_addr  <= '0;
      r_haddr      <= '0;
      r_htrans     <= c_HT_IDLE;
      r_hburst     <= c_HB_SINGLE;
      r_hwrite     <= 1'b0;
      r_dp_pending <= 1'b0;
      r_dp_last    <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_write      <= w_write;
      r_len        <= w_len;
      r_burst      <= w_burst;
      r_hb_code    <= w_hb_code;
      r_single     <= w_single;
      r_cnt        <= w_cnt;
      r_next_addr  <= w_next_addr;
      r_haddr      <= w_haddr;
      r_htrans     <= w_htrans;
      r_hburst     <= w_hburst;
      r_hwrite     <= w_hwrite;
      r_dp_pending <= w_dp_pending;
      r_dp_last    <= w_dp_last;
      r_err        <= w_err;
    end
  end

  assign bus.cmd_ready_o    = (r_state == S_IDLE);
  assign bus.HADDR          = r_haddr;
  assign bus.HBURST         = r_hburst;
  assign bus.HSIZE          = c_HSIZE;
  assign bus.HTRANS         = r_htrans;
  assign bus.HWRITE         = r_hwrite;
  assign bus.dphase_valid_o = r_dp_pending && bus.HREADY;
  assign bus.dphase_last_o  = r_dp_last && bus.HREADY;
  assign bus.err_o          = r_err;

endmodule
`default_nettype wire
